// File: rtl/rx_controller_if.sv
// Frame ingress from the CRC stage and payload delivery to the
// consumer; the controller sits on the slave side.
interface rx_controller_if #(
    parameter int FW = 256,
    parameter int PW = 240
);
    logic [FW-1:0] rifl_rx_data;
    logic          rifl_rx_vld;
    logic          crc_good;
    logic [PW+1:0] rifl_rx_payload;
    logic          rifl_rx_valid;

    modport master (
        output rifl_rx_data,
        output rifl_rx_vld,
        output crc_good,
        input  rifl_rx_payload,
        input  rifl_rx_valid
    );

    modport slave (
        input  rifl_rx_data,
        input  rifl_rx_vld,
        input  crc_good,
        output rifl_rx_payload,
        output rifl_rx_valid
    );
endinterface

// File: rtl/rx_controller.sv
// Receive link controller: frame decode, link bring-up, error
// drop and replay skip ahead of in-order payload delivery.
module rx_controller #(
    parameter int FRAME_WIDTH    = 256,
    parameter int PAYLOAD_WIDTH  = 240,
    parameter int CRC_WIDTH      = 12,
    parameter int FRAME_ID_WIDTH = 8,
    parameter int UP_THRESH      = 64
) (
    input  logic           clk,
    input  logic           rst,
    rx_controller_if.slave rx,
    output logic           rx_up,
    output logic           rx_error,
    output logic           pause_req,
    output logic           retrans_req,
    output logic           remote_fc,
    output logic [2:0]     state
);
    localparam int FW = FRAME_WIDTH;
    localparam int PW = PAYLOAD_WIDTH;
    localparam int CW = FRAME_ID_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(2 ** FRAME_ID_WIDTH);
    localparam logic [CW-1:0] LAST  = CW'(2 ** FRAME_ID_WIDTH - 1);
    localparam logic [CW-1:0] THR   = CW'(UP_THRESH - 1);
    localparam logic [15:0] K_PAUSE   = 16'h0010;
    localparam logic [15:0] K_RETRANS = 16'h1000;

    typedef enum logic [2:0] {
        S_DOWN   = 3'd0,
        S_UP     = 3'd1,
        S_ERROR  = 3'd2,
        S_REPLAY = 3'd3
    } state_t;

    state_t st_q, st_d;
    logic [CW-1:0] good_q, good_d, bad_q, bad_d;
    logic [CW-1:0] dlv_q, dlv_d, post_q, post_d;
    logic [CW-1:0] skip_q, skip_d, rpl_q, rpl_d;
    logic [CW-1:0] room;
    logic          up_d, err_d, pause_d, rt_d, fc_d, vld_d;
    logic [PW+1:0] pl_q, pl_d;

    logic [1:0]    hdr;
    logic [15:0]   key;
    logic [PW+1:0] pl;
    logic good, bad, is_ctl, is_dat;
    logic fc_on, fc_off, take;
    logic unused_crc;

    assign hdr    = rx.rifl_rx_data[FW-1 -: 2];
    assign key    = rx.rifl_rx_data[FW-3 -: 16];
    assign pl     = rx.rifl_rx_data[FW-3:CRC_WIDTH];
    assign good   = rx.rifl_rx_vld & rx.crc_good
                  & (hdr == 2'b10 | hdr == 2'b01);
    assign bad    = rx.rifl_rx_vld & ~good;
    assign is_ctl = good & (hdr == 2'b10);
    assign is_dat = good & (hdr == 2'b01);
    assign fc_on  = is_dat & (pl[PW+1:PW] == 2'b00)
                  & (pl[7:0] == 8'h01);
    assign fc_off = is_dat & (pl[PW+1:PW] == 2'b00)
                  & (pl[7:0] == 8'h02);
    assign room   = LAST - post_q;
    assign unused_crc = ^rx.rifl_rx_data[CRC_WIDTH-1:0];

    // Frames past the replay skip point are handled as in UP
    assign take = is_dat & ((st_q == S_UP)
                | (st_q == S_REPLAY & rpl_q >= skip_q));

    function automatic logic [CW-1:0] inc_sat(
        input logic [CW-1:0] v,
        input logic [CW-1:0] lim
    );
        return (v < lim) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        st_d    = st_q;
        good_d  = good_q;
        bad_d   = bad_q;
        dlv_d   = dlv_q;
        post_d  = post_q;
        skip_d  = skip_q;
        rpl_d   = rpl_q;
        up_d    = rx_up;
        err_d   = rx_error;
        pause_d = pause_req;
        rt_d    = retrans_req;
        fc_d    = remote_fc;
        vld_d   = 1'b0;
        pl_d    = pl_q;

        if (st_q != S_DOWN) begin
            if (good)
                bad_d = '0;
            else if (bad)
                bad_d = inc_sat(bad_q, DEPTH);
            if (is_ctl) begin
                pause_d = (key == K_PAUSE);
                rt_d    = (key == K_RETRANS);
            end
        end

        unique case (st_q)
            S_DOWN: begin
                if (bad) begin
                    good_d = '0;
                end else if (good) begin
                    if (good_q == THR) begin
                        st_d   = S_UP;
                        up_d   = 1'b1;
                        good_d = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
            end
            S_UP: begin
                if (is_dat)
                    dlv_d = inc_sat(dlv_q, DEPTH);
                if (bad) begin
                    st_d   = S_ERROR;
                    err_d  = 1'b1;
                    post_d = '0;
                end
            end
            S_ERROR: begin
                if (is_dat)
                    post_d = inc_sat(post_q, LAST);
                if (is_ctl) begin
                    st_d   = S_REPLAY;
                    rpl_d  = '0;
                    skip_d = (dlv_q < room) ? dlv_q : room;
                end
            end
            S_REPLAY: begin
                if (is_dat) begin
                    err_d = 1'b0;
                    if (rpl_q == LAST) begin
                        st_d  = S_UP;
                        dlv_d = DEPTH;
                    end else begin
                        rpl_d = rpl_q + 1'b1;
                    end
                end
                if (bad) begin
                    st_d   = S_ERROR;
                    err_d  = 1'b1;
                    post_d = '0;
                    dlv_d  = (rpl_q > skip_q) ? rpl_q : skip_q;
                end
            end
            default: st_d = S_DOWN;
        endcase

        if (take) begin
            if (fc_on)
                fc_d = 1'b1;
            else if (fc_off)
                fc_d = 1'b0;
            else begin
                vld_d = 1'b1;
                pl_d  = pl;
            end
        end

        // Link loss starts a fresh link: flags and windows cleared
        if (bad && st_q != S_DOWN && bad_q == THR) begin
            st_d    = S_DOWN;
            up_d    = 1'b0;
            err_d   = 1'b0;
            pause_d = 1'b0;
            rt_d    = 1'b0;
            fc_d    = 1'b0;
            vld_d   = 1'b0;
            good_d  = '0;
            bad_d   = '0;
            dlv_d   = '0;
            post_d  = '0;
            skip_d  = '0;
            rpl_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= S_DOWN;
            good_q      <= '0;
            bad_q       <= '0;
            dlv_q       <= '0;
            post_q      <= '0;
            skip_q      <= '0;
            rpl_q       <= '0;
            rx_up       <= 1'b0;
            rx_error    <= 1'b0;
            pause_req   <= 1'b0;
            retrans_req <= 1'b0;
            remote_fc   <= 1'b0;
            pl_q        <= '0;
            rx.rifl_rx_valid <= 1'b0;
        end else begin
            st_q        <= st_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            dlv_q       <= dlv_d;
            post_q      <= post_d;
            skip_q      <= skip_d;
            rpl_q       <= rpl_d;
            rx_up       <= up_d;
            rx_error    <= err_d;
            pause_req   <= pause_d;
            retrans_req <= rt_d;
            remote_fc   <= fc_d;
            pl_q        <= pl_d;
            rx.rifl_rx_valid <= vld_d;
        end
    end

    assign rx.rifl_rx_payload = pl_q;
    assign state = st_q;
endmodule

// File: tb/tb_rx_controller.sv
// Bench for rx_controller: random frames against a behavioural
// link model, plus directed bring-up, replay and reset scenarios.
module tb_rx_controller;
    localparam int FW    = 256;
    localparam int PW    = 240;
    localparam int DEPTH = 256;
    localparam int THR   = 64;

    logic clk = 1'b0;
    logic rst;
    logic rx_up, rx_error, pause_req, retrans_req, remote_fc;
    logic [2:0] state;

    always #5 clk = ~clk;

    rx_controller_if #(.FW(FW), .PW(PW)) ifc ();

    rx_controller dut (
        .clk(clk),
        .rst(rst),
        .rx(ifc),
        .rx_up(rx_up),
        .rx_error(rx_error),
        .pause_req(pause_req),
        .retrans_req(retrans_req),
        .remote_fc(remote_fc),
        .state(state)
    );

    int checks = 0;
    int errors = 0;

    // Link model: mode 0 down, 1 up, 2 error, 3 replay
    int m_mode, m_good, m_bad, m_dlv, m_post, m_skip, m_rpl;
    bit m_err, m_pause, m_rt, m_fc, m_valid;
    logic [PW+1:0] m_pl;

    task automatic m_reset();
        m_mode = 0; m_good = 0; m_bad = 0; m_dlv = 0;
        m_post = 0; m_skip = 0; m_rpl = 0;
        m_err = 0; m_pause = 0; m_rt = 0; m_fc = 0;
        m_valid = 0; m_pl = '0;
    endtask

    task automatic model(input logic [FW-1:0] f, input bit v,
                         input bit c);
        logic [1:0] h;
        logic [15:0] k;
        logic [PW+1:0] p;
        bit good, ctl, dat, fon, foff, take;
        h = f[FW-1 -: 2];
        k = f[FW-3 -: 16];
        p = f[FW-3:12];
        good = v && c && (h == 2'b10 || h == 2'b01);
        ctl  = good && h == 2'b10;
        dat  = good && h == 2'b01;
        fon  = dat && p[PW+1:PW] == 2'b00 && p[7:0] == 8'h01;
        foff = dat && p[PW+1:PW] == 2'b00 && p[7:0] == 8'h02;
        take = 0;
        m_valid = 0;
        if (!v) return;
        if (m_mode != 0) begin
            m_bad = good ? 0 : m_bad + 1;
            if (m_bad == THR) begin
                m_reset();
                return;
            end
            if (ctl) begin
                m_pause = (k == 16'h0010);
                m_rt    = (k == 16'h1000);
            end
        end
        case (m_mode)
            0: begin
                m_good = good ? m_good + 1 : 0;
                if (m_good == THR) begin
                    m_mode = 1;
                    m_good = 0;
                end
            end
            1: begin
                if (!good) begin
                    m_mode = 2; m_err = 1; m_post = 0;
                end else if (dat) begin
                    m_dlv = (m_dlv + 1 > DEPTH) ? DEPTH : m_dlv + 1;
                    take = 1;
                end
            end
            2: begin
                if (dat) begin
                    if (m_post < DEPTH - 1) m_post++;
                end else if (ctl) begin
                    m_skip = (m_dlv < DEPTH - 1 - m_post)
                           ? m_dlv : DEPTH - 1 - m_post;
                    m_rpl = 0;
                    m_mode = 3;
                end
            end
            default: begin
                if (!good) begin
                    m_mode = 2; m_err = 1; m_post = 0;
                    m_dlv = (m_rpl > m_skip) ? m_rpl : m_skip;
                end else if (dat) begin
                    m_err = 0;
                    take = (m_rpl >= m_skip);
                    m_rpl++;
                    if (m_rpl == DEPTH) begin
                        m_mode = 1;
                        m_dlv = DEPTH;
                    end
                end
            end
        endcase
        if (take) begin
            if (fon) m_fc = 1;
            else if (foff) m_fc = 0;
            else begin
                m_valid = 1;
                m_pl = p;
            end
        end
    endtask

    function automatic logic [FW-1:0] rnd_bits();
        logic [FW-1:0] r;
        for (int i = 0; i < FW / 32; i++)
            r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [FW-1:0] mk_ctl(input logic [15:0] k);
        logic [FW-1:0] f;
        f = rnd_bits();
        f[FW-1 -: 2] = 2'b10;
        f[FW-3 -: 16] = k;
        return f;
    endfunction

    function automatic logic [FW-1:0] mk_dat();
        logic [FW-1:0] f;
        f = rnd_bits();
        f[FW-1 -: 2] = 2'b01;
        f[FW-3 -: 2] = 2'($urandom_range(1, 3));
        return f;
    endfunction

    function automatic logic [FW-1:0] mk_fc(input bit on);
        logic [FW-1:0] f;
        f = rnd_bits();
        f[FW-1 -: 2] = 2'b01;
        f[FW-3 -: 2] = 2'b00;
        f[19:12] = on ? 8'h01 : 8'h02;
        return f;
    endfunction

    function automatic logic [FW-1:0] mk_badhdr();
        logic [FW-1:0] f;
        f = rnd_bits();
        f[FW-1 -: 2] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        return f;
    endfunction

    task automatic send(input logic [FW-1:0] f, input bit v,
                        input bit c);
        @(negedge clk);
        ifc.rifl_rx_data = f;
        ifc.rifl_rx_vld  = v;
        ifc.crc_good     = c;
        model(f, v, c);
        @(posedge clk);
        #1;
        ifc.rifl_rx_vld = 1'b0;
    endtask

    task automatic send_bad();
        if ($urandom_range(0, 1) == 0) send(mk_dat(), 1, 0);
        else send(mk_badhdr(), 1, 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.rifl_rx_data = '0;
        ifc.rifl_rx_vld  = 1'b0;
        ifc.crc_good     = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_up, rx_error, pause_req, retrans_req, remote_fc,
             ifc.rifl_rx_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 000000",
                     {rx_up, rx_error, pause_req, retrans_req,
                      remote_fc, ifc.rifl_rx_valid});
        end
        checks++;
        if (state !== 3'd0 || ifc.rifl_rx_payload !== '0) begin
            errors++;
            $display("FAIL reset_state: state=%0d payload=%h exp 0",
                     state, ifc.rifl_rx_payload);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_link_up();
        for (int i = 0; i < 10; i++) send(mk_ctl(16'h0001), 1, 1);
        send(mk_ctl(16'h0001), 1, 0);
        for (int i = 0; i < THR - 1; i++) begin
            if ($urandom_range(0, 3) == 0) send(rnd_bits(), 0, 1);
            send(mk_ctl(16'($urandom)), 1, 1);
            checks++;
            if (rx_up !== 1'b0 || state !== 3'd0) begin
                errors++;
                $display("FAIL link_up_early %0d: rx_up=%b state=%0d exp 0/0",
                         i, rx_up, state);
            end
        end
        send(mk_ctl(16'h0001), 1, 1);
        checks++;
        if (rx_up !== 1'b1 || state !== 3'd1) begin
            errors++;
            $display("FAIL link_up: rx_up=%b state=%0d exp 1/1",
                     rx_up, state);
        end
    endtask

    task automatic test_data();
        logic [FW-1:0] f;
        logic [247:0] a5;
        logic [PW+1:0] want;
        int kind;
        a5 = {31{8'hA5}};
        want = a5[247:6];
        f = '0;
        f[FW-1 -: 2] = 2'b01;
        f[FW-3:12] = want;
        send(f, 1, 1);
        checks++;
        if (ifc.rifl_rx_valid !== 1'b1 || ifc.rifl_rx_payload !== want) begin
            errors++;
            $display("FAIL data_a5: valid=%b payload=%h exp 1 %h",
                     ifc.rifl_rx_valid, ifc.rifl_rx_payload, want);
        end
        send(mk_fc(1), 1, 1);
        checks++;
        if (remote_fc !== 1'b1 || ifc.rifl_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL fc_on: fc=%b valid=%b exp 1 0",
                     remote_fc, ifc.rifl_rx_valid);
        end
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6) send(mk_dat(), 1, 1);
            else if (kind == 6) send(mk_fc(1), 1, 1);
            else if (kind == 7) send(mk_fc(0), 1, 1);
            else send(mk_dat(), 0, 1);
            checks++;
            if (ifc.rifl_rx_valid !== m_valid || remote_fc !== m_fc ||
                (m_valid && ifc.rifl_rx_payload !== m_pl)) begin
                errors++;
                $display("FAIL data_rand %0d: valid=%b fc=%b pl=%h exp %b %b %h",
                         i, ifc.rifl_rx_valid, remote_fc,
                         ifc.rifl_rx_payload, m_valid, m_fc, m_pl);
            end
        end
    endtask

    task automatic test_ctrl();
        logic [15:0] keys [6] = '{16'h0010, 16'h0001, 16'h1000,
                                  16'h0F0F, 16'h0010, 16'h0010};
        bit          vlds [6] = '{1, 1, 1, 1, 1, 0};
        logic [1:0]  exps [6] = '{2'b10, 2'b00, 2'b01,
                                  2'b00, 2'b10, 2'b10};
        for (int i = 0; i < 6; i++) begin
            send(mk_ctl(keys[i]), vlds[i], 1);
            checks++;
            if ({pause_req, retrans_req} !== exps[i] ||
                ifc.rifl_rx_valid !== 1'b0) begin
                errors++;
                $display("FAIL ctrl %0d: pause/rt=%b valid=%b exp %b 0",
                         i, {pause_req, retrans_req},
                         ifc.rifl_rx_valid, exps[i]);
            end
        end
    endtask

    task automatic test_replay();
        logic [FW-1:0] f;
        logic [PW+1:0] rp [DEPTH];
        logic [PW+1:0] got [4];
        int n;
        for (int i = 0; i < 300; i++) begin
            send(mk_dat(), 1, 1);
            checks++;
            if (ifc.rifl_rx_valid !== 1'b1 || ifc.rifl_rx_payload !== m_pl) begin
                errors++;
                $display("FAIL prefill %0d: valid=%b pl=%h exp 1 %h",
                         i, ifc.rifl_rx_valid, ifc.rifl_rx_payload, m_pl);
            end
        end
        send(mk_dat(), 1, 0);
        checks++;
        if (state !== 3'd2 || rx_error !== 1'b1 || ifc.rifl_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL enter_error: state=%0d err=%b valid=%b exp 2 1 0",
                     state, rx_error, ifc.rifl_rx_valid);
        end
        for (int i = 0; i < 3; i++) begin
            send(mk_dat(), 1, 1);
            checks++;
            if (ifc.rifl_rx_valid !== 1'b0) begin
                errors++;
                $display("FAIL error_drop %0d: valid=%b exp 0",
                         i, ifc.rifl_rx_valid);
            end
        end
        send(mk_ctl(16'h0001), 1, 1);
        checks++;
        if (state !== 3'd3 || rx_error !== 1'b1) begin
            errors++;
            $display("FAIL enter_replay: state=%0d err=%b exp 3 1",
                     state, rx_error);
        end
        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            f = mk_dat();
            rp[i] = f[FW-3:12];
            send(f, 1, 1);
            if (ifc.rifl_rx_valid === 1'b1) begin
                if (n < 4) got[n] = ifc.rifl_rx_payload;
                n++;
            end
            if (i == 0) begin
                checks++;
                if (rx_error !== 1'b0) begin
                    errors++;
                    $display("FAIL replay_err_clear: err=%b exp 0", rx_error);
                end
            end
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL replay_count: delivered=%0d exp 4", n);
        end
        for (int j = 0; j < 4 && j < n; j++) begin
            checks++;
            if (got[j] !== rp[252 + j]) begin
                errors++;
                $display("FAIL replay_order %0d: pl=%h exp %h",
                         j, got[j], rp[252 + j]);
            end
        end
        checks++;
        if (state !== 3'd1 || rx_error !== 1'b0 || rx_up !== 1'b1) begin
            errors++;
            $display("FAIL replay_done: state=%0d err=%b up=%b exp 1 0 1",
                     state, rx_error, rx_up);
        end
    endtask

    task automatic test_replay_err();
        send_bad();
        send(mk_dat(), 1, 1);
        send(mk_dat(), 1, 1);
        send(mk_ctl(16'h0001), 1, 1);
        for (int i = 0; i < 10; i++) send(mk_dat(), 1, 1);
        send_bad();
        checks++;
        if (state !== 3'd2 || rx_error !== 1'b1) begin
            errors++;
            $display("FAIL replay_bad: state=%0d err=%b exp 2 1",
                     state, rx_error);
        end
        for (int i = 0; i < 5; i++) begin
            send(mk_dat(), 1, 1);
            checks++;
            if (ifc.rifl_rx_valid !== 1'b0 || state !== 3'd2) begin
                errors++;
                $display("FAIL rerror_drop %0d: valid=%b state=%0d exp 0 2",
                         i, ifc.rifl_rx_valid, state);
            end
        end
        send(mk_ctl(16'h1000), 1, 1);
        for (int i = 0; i < DEPTH; i++) begin
            send(mk_dat(), 1, 1);
            checks++;
            if (ifc.rifl_rx_valid !== m_valid ||
                (m_valid && ifc.rifl_rx_payload !== m_pl)) begin
                errors++;
                $display("FAIL replay2 %0d: valid=%b pl=%h exp %b %h",
                         i, ifc.rifl_rx_valid, ifc.rifl_rx_payload,
                         m_valid, m_pl);
            end
        end
        checks++;
        if (state !== 3'd1 || rx_error !== 1'b0) begin
            errors++;
            $display("FAIL replay2_done: state=%0d err=%b exp 1 0",
                     state, rx_error);
        end
    endtask

    task automatic test_link_loss();
        send(mk_ctl(16'h0010), 1, 1);
        send(mk_fc(1), 1, 1);
        checks++;
        if (pause_req !== 1'b1 || remote_fc !== 1'b1) begin
            errors++;
            $display("FAIL loss_pre: pause=%b fc=%b exp 1 1",
                     pause_req, remote_fc);
        end
        for (int i = 0; i < THR - 1; i++) send_bad();
        checks++;
        if (rx_up !== 1'b1 || state !== 3'd2) begin
            errors++;
            $display("FAIL loss_63: up=%b state=%0d exp 1 2", rx_up, state);
        end
        send_bad();
        checks++;
        if ({rx_up, rx_error, pause_req, retrans_req, remote_fc} !== 5'b0 ||
            state !== 3'd0) begin
            errors++;
            $display("FAIL loss_64: flags=%b state=%0d exp 00000 0",
                     {rx_up, rx_error, pause_req, retrans_req, remote_fc},
                     state);
        end
    endtask

    task automatic test_async_rst();
        for (int i = 0; i < THR; i++) send(mk_ctl(16'h0001), 1, 1);
        send(mk_fc(1), 1, 1);
        send_bad();
        send(mk_ctl(16'h0001), 1, 1);
        send(mk_dat(), 1, 1);
        send(mk_dat(), 1, 1);
        checks++;
        if (ifc.rifl_rx_valid !== m_valid || state !== 3'd3 ||
            remote_fc !== 1'b1 || ifc.rifl_rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst: valid=%b state=%0d fc=%b exp 1 3 1",
                     ifc.rifl_rx_valid, state, remote_fc);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rx_up, rx_error, pause_req, retrans_req, remote_fc,
             ifc.rifl_rx_valid} !== 6'b0 || state !== 3'd0) begin
            errors++;
            $display("FAIL async_rst: flags=%b state=%0d exp 000000 0",
                     {rx_up, rx_error, pause_req, retrans_req,
                      remote_fc, ifc.rifl_rx_valid}, state);
        end
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        send(mk_dat(), 1, 1);
        checks++;
        if (state !== 3'd0 || ifc.rifl_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_rst: state=%0d valid=%b exp 0 0",
                     state, ifc.rifl_rx_valid);
        end
    endtask

    initial begin
        test_reset();
        test_link_up();
        test_data();
        test_ctrl();
        test_replay();
        test_replay_err();
        test_link_loss();
        test_async_rst();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
